// File: rtl/prod_accum_if.sv
// Product-in / frame-sum-out handshake bundle for prod_accum.
// slave = accumulator side, master = producer/consumer side.
interface prod_accum_if #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_ovf;

  modport slave (
    input  in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );

  modport master (
    output in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/prod_accum.sv
// Sums FRAME_LEN products per frame and holds the result until the consumer takes it.
// Build with PROD_ACCUM_SAT_EN defined to clamp on overflow instead of wrapping.
module prod_accum #(
  parameter int PROD_W    = 8,
  parameter int ACC_W     = 10,
  parameter int FRAME_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  prod_accum_if.slave bus
);
  localparam int               CNT_W    = $clog2(FRAME_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = '1;

  typedef enum logic {ST_ACCUM, ST_HOLD} state_t;

  state_t           state_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q, ovf_d;
  logic             out_valid_q;
  logic [ACC_W-1:0] out_sum_q;
  logic             out_ovf_q;

  logic [ACC_W:0]   add_full;
  logic             accept;

  assign bus.in_ready  = (state_q == ST_ACCUM) && !clear;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_ovf   = out_ovf_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign add_full = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.in_prod};
  assign ovf_d    = ovf_q | add_full[ACC_W];

`ifdef PROD_ACCUM_SAT_EN
  // Once the frame has overflowed the accumulator stays pinned at full scale.
  assign acc_d = ovf_d ? ACC_MAX : add_full[ACC_W-1:0];
`else
  assign acc_d = add_full[ACC_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else if (clear) begin
      // out_sum/out_ovf keep their last value; only the pending valid is dropped.
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (accept) begin
            if (cnt_q == LAST_CNT) begin
              out_sum_q   <= acc_d;
              out_ovf_q   <= ovf_d;
              out_valid_q <= 1'b1;
              acc_q       <= '0;
              cnt_q       <= '0;
              ovf_q       <= 1'b0;
              state_q     <= ST_HOLD;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_q + 1'b1;
              ovf_q <= ovf_d;
            end
          end
        end
        ST_HOLD: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_ACCUM;
          end
        end
      endcase
    end
  end

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_q && !bus.out_ready && !clear) |=> (out_valid_q && $stable(out_sum_q) && $stable(out_ovf_q)));

  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= LAST_CNT);

endmodule

// File: tb/tb_prod_accum.sv
// Three accumulators (nominal, 9-bit overflow-prone, single-product frames) share one stimulus stream.
// Each is compared cycle by cycle against an integer-sum reference model.
module tb_prod_accum;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_prod;

  always #5 clk = ~clk;

  prod_accum_if #(.PROD_W(8), .ACC_W(10)) if_a ();
  prod_accum_if #(.PROD_W(8), .ACC_W(9))  if_b ();
  prod_accum_if #(.PROD_W(8), .ACC_W(10)) if_c ();

  assign if_a.in_valid = in_valid;  assign if_a.in_prod = in_prod;  assign if_a.out_ready = out_ready;
  assign if_b.in_valid = in_valid;  assign if_b.in_prod = in_prod;  assign if_b.out_ready = out_ready;
  assign if_c.in_valid = in_valid;  assign if_c.in_prod = in_prod;  assign if_c.out_ready = out_ready;

  prod_accum #(.PROD_W(8), .ACC_W(10), .FRAME_LEN(4)) dut_a (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(if_a));
  prod_accum #(.PROD_W(8), .ACC_W(9),  .FRAME_LEN(4)) dut_b (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(if_b));
  prod_accum #(.PROD_W(8), .ACC_W(10), .FRAME_LEN(1)) dut_c (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(if_c));

  logic [31:0] o_rdy [3];
  logic [31:0] o_vld [3];
  logic [31:0] o_sum [3];
  logic [31:0] o_ovf [3];

  assign o_rdy[0] = 32'(if_a.in_ready);  assign o_rdy[1] = 32'(if_b.in_ready);  assign o_rdy[2] = 32'(if_c.in_ready);
  assign o_vld[0] = 32'(if_a.out_valid); assign o_vld[1] = 32'(if_b.out_valid); assign o_vld[2] = 32'(if_c.out_valid);
  assign o_sum[0] = 32'(if_a.out_sum);   assign o_sum[1] = 32'(if_b.out_sum);   assign o_sum[2] = 32'(if_c.out_sum);
  assign o_ovf[0] = 32'(if_a.out_ovf);   assign o_ovf[1] = 32'(if_b.out_ovf);   assign o_ovf[2] = 32'(if_c.out_ovf);

  // Reference model: per instance, true integer sum of the products accepted this frame.
  int frame_len [3] = '{4, 4, 1};
  int acc_width [3] = '{10, 9, 10};
  int m_cnt  [3];
  int m_tsum [3];
  int m_sum  [3];
  bit m_ovf  [3];
  bit m_hold [3];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int frame_result(input int idx, input int tsum);
    int max_val;
    max_val = (1 << acc_width[idx]) - 1;
    if (tsum <= max_val) return tsum;
`ifdef PROD_ACCUM_SAT_EN
    return max_val;
`else
    return tsum % (1 << acc_width[idx]);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_tsum[i] = 0; m_sum[i] = 0; m_ovf[i] = 1'b0; m_hold[i] = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s.vld%0d", tag, i), o_vld[i], 32'(m_hold[i]));
      check($sformatf("%s.sum%0d", tag, i), o_sum[i], 32'(m_sum[i]));
      check($sformatf("%s.ovf%0d", tag, i), o_ovf[i], 32'(m_ovf[i]));
    end
  endtask

  task automatic check_ready(input string tag);
    for (int i = 0; i < 3; i++)
      check($sformatf("%s.rdy%0d", tag, i), o_rdy[i], 32'(!m_hold[i] && !clear));
  endtask

  // One clock: drive at negedge, check ready before the edge, check outputs after it.
  task automatic cycle(input bit v, input int p, input bit ordy, input bit clr, input string tag);
    @(negedge clk);
    in_valid  = v;
    in_prod   = 8'(p);
    out_ready = ordy;
    clear     = clr;
    #1;
    check_ready(tag);
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        m_hold[i] = 1'b0; m_cnt[i] = 0; m_tsum[i] = 0;
      end else if (m_hold[i]) begin
        if (ordy) m_hold[i] = 1'b0;
      end else if (v) begin
        m_tsum[i] += p;
        m_cnt[i]++;
        if (m_cnt[i] == frame_len[i]) begin
          m_sum[i]  = frame_result(i, m_tsum[i]);
          m_ovf[i]  = (m_tsum[i] > (1 << acc_width[i]) - 1);
          m_hold[i] = 1'b1;
          m_cnt[i]  = 0;
          m_tsum[i] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_prod = '0; out_ready = 1'b0;
    model_reset();
    #3;
    check_outputs("reset");
    check_ready("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back full-scale frame: exact on 10 bits, overflows 9 bits.
    for (int k = 0; k < 4; k++) cycle(1'b1, 225, 1'b1, 1'b0, "t2");
    check("t2_sum", o_sum[0], 32'd900);
    check("t2_ovf", o_ovf[0], 32'd0);
    check("t2_vld", o_vld[0], 32'd1);
    check("t2_rdy", o_rdy[0], 32'd0);
`ifdef PROD_ACCUM_SAT_EN
    check("t5_sum9", o_sum[1], 32'd511);
`else
    check("t5_sum9", o_sum[1], 32'd388);
`endif
    check("t5_ovf9", o_ovf[1], 32'd1);
    cycle(1'b0, 0, 1'b1, 1'b0, "drain");

    // Backpressure: result must sit still while input keeps being offered.
    cycle(1'b1, 17, 1'b1, 1'b0, "t3f");
    cycle(1'b1, 33, 1'b1, 1'b0, "t3f");
    cycle(1'b1, 64, 1'b1, 1'b0, "t3f");
    cycle(1'b1, 200, 1'b0, 1'b0, "t3f");
    for (int k = 0; k < 5; k++) cycle(1'b1, 99, 1'b0, 1'b0, "t3bp");
    check("t3_sum", o_sum[0], 32'd314);
    cycle(1'b0, 0, 1'b1, 1'b0, "t3hs");
    check("t3_rdy_after", o_rdy[0], 32'd1);
    cycle(1'b0, 0, 1'b1, 1'b0, "drain");

    // Gapped input: only valid beats count.
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 3 + 2 * k, 1'b1, 1'b0, "t4");
      if (k < 3) begin
        check("t4_vld_early", o_vld[0], 32'd0);
        cycle(1'b0, int'($urandom_range(255)), 1'b1, 1'b0, "t4gap");
      end
    end
    check("t4_sum", o_sum[0], 32'd24);
    cycle(1'b0, 0, 1'b1, 1'b0, "drain");

    // Clear mid-frame with a product offered: that product and the partial sum are dropped.
    cycle(1'b1, 10, 1'b1, 1'b0, "t6");
    cycle(1'b1, 20, 1'b1, 1'b0, "t6");
    cycle(1'b1, 55, 1'b1, 1'b1, "t6clr");
    for (int k = 1; k <= 4; k++) cycle(1'b1, k, 1'b1, 1'b0, "t6");
    check("t6_sum", o_sum[0], 32'd10);
    check("t6_ovf", o_ovf[0], 32'd0);
    cycle(1'b0, 0, 1'b1, 1'b0, "drain");

    // Async reset mid-frame after two products; the next frame starts from zero.
    cycle(1'b1, 150, 1'b1, 1'b0, "t1");
    cycle(1'b1, 150, 1'b1, 1'b0, "t1");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("t1rst");
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) cycle(1'b1, 5, 1'b1, 1'b0, "t1post");
    check("t1_sum", o_sum[0], 32'd20);

    // Random traffic.
    for (int k = 0; k < 600; k++)
      cycle(($urandom % 4) != 0, int'($urandom_range(255)), ($urandom % 3) != 0,
            ($urandom % 50) == 0, "rnd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
